// File: rtl/systolic_feeder.sv
// systolic_feeder: operand sequencer for the input edge of an NxN systolic MAC array.
// Accepts one k-slice per handshake (A column + B row), skews lane r by r cycles,
// sequences clear/enable for the array, drains the pipeline and pulses done.
module systolic_feeder #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int K_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [K_W-1:0]             k_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0][DATA_W-1:0]   in_a,
    input  logic [N-1:0][DATA_W-1:0]   in_b,
    output logic [N-1:0][DATA_W-1:0]   a_left,
    output logic [N-1:0][DATA_W-1:0]   b_top,
    output logic                       en,
    output logic                       clear_acc,
    output logic                       busy,
    output logic                       done
);

    // The drain has to cover the longest skew path through the array: 2N-1 cycles.
    localparam int                 DRAIN_W   = $clog2(2 * N);
    localparam logic [DRAIN_W-1:0] DRAIN_LEN = DRAIN_W'(2 * N - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [K_W-1:0]     slice_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               accept;

    assign accept = in_ready && in_valid;

    // State register; reset aborts any tile in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: tile sequencing from start to done.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                state_next = (slice_cnt != '0) ? FEED : DONE;
            end
            FEED: begin
                if (accept && slice_cnt == K_W'(1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode; depends on state only, so in_ready never sees in_valid.
    always_comb begin
        in_ready  = 1'b0;
        en        = 1'b0;
        clear_acc = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
            end
            CLEAR: begin
                clear_acc = 1'b1;
            end
            FEED: begin
                in_ready = 1'b1;
                en       = 1'b1;
            end
            DRAIN: begin
                en = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Remaining-slice counter (loaded on start) and drain counter (loaded on last slice).
    always_ff @(posedge clk) begin
        if (rst) begin
            slice_cnt <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                slice_cnt <= k_len;
            end else if (accept) begin
                slice_cnt <= slice_cnt - K_W'(1);
            end

            if (accept && slice_cnt == K_W'(1)) begin
                drain_cnt <= DRAIN_LEN;
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt - DRAIN_W'(1);
            end
        end
    end

    // Per-lane skew: stage 0 captures the accepted slice (zero otherwise), then r more stages.
    for (genvar r = 0; r < N; r++) begin : g_lane
        logic [DATA_W-1:0] a_dly [0:r];
        logic [DATA_W-1:0] b_dly [0:r];

        // Delay line for lane r; shifts every cycle so idle states flush zeros through.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j <= r; j++) begin
                    a_dly[j] <= '0;
                    b_dly[j] <= '0;
                end
            end else begin
                a_dly[0] <= accept ? in_a[r] : '0;
                b_dly[0] <= accept ? in_b[r] : '0;
                for (int j = 1; j <= r; j++) begin
                    a_dly[j] <= a_dly[j-1];
                    b_dly[j] <= b_dly[j-1];
                end
            end
        end

        assign a_left[r] = a_dly[r];
        assign b_top[r]  = b_dly[r];
    end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Operand sequencer that drives the input edge of the NxN systolic MAC array.
- Accepts one k-slice per handshake from the operand buffer: one column of A (N values) and one row of B (N values).
- Applies the diagonal skew (lane r delayed r cycles) and generates the array's clear_acc/en.
- Drains the pipeline after the last slice, then pulses done when every c_out[r][c] holds the full dot product.

Parameters:
N, 4, array dimension (lanes per side)
DATA_W, 16, signed operand width
K_W, 16, width of reduction-length field k_len

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a tile; sampled only in IDLE
k_len  in  K_W  number of k-slices in tile (unsigned), latched on accepted start
in_valid  in  1  slice available
in_ready  out  1  feeder accepts slice this cycle
in_a  in  N x DATA_W signed  A column, element r for row lane r
in_b  in  N x DATA_W signed  B row, element c for column lane c
a_left  out  N x DATA_W signed  skewed row operands to array
b_top  out  N x DATA_W signed  skewed column operands to array
en  out  1  array advance/accumulate enable
clear_acc  out  1  array accumulator clear
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse: array results final

Behaviour:
- Reset: state IDLE.
  - a_left, b_top, all skew registers = 0.
  - en = clear_acc = done = busy = in_ready = 0.
  - rst overrides everything, including mid-tile. No done is issued for an aborted tile.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
  - IDLE: start=1 latches k_len into the remaining-slice counter and goes to CLEAR.
  - CLEAR (1 cycle): clear_acc=1, en=0. Next state is FEED if latched k_len>0, else DONE.
  - FEED: in_ready=1, en=1.
    - A slice is accepted when in_valid && in_ready; acceptance decrements the counter.
    - A cycle with in_valid=0 injects an all-zero bubble slice into all lanes. Zero products leave results unchanged. en stays 1.
    - Accepting the last slice (counter 1 -> 0) goes to DRAIN and loads the drain counter with 2N-1.
  - DRAIN: en=1, in_ready=0, zeros injected. Decrement each cycle; leaving on reaching 0 gives exactly 2N-1 DRAIN cycles, then DONE.
  - DONE (1 cycle): done=1, en=0, next state IDLE.
- start outside IDLE is ignored.
- en=0 in IDLE, CLEAR and DONE, so array accumulators hold their values after done until the next tile's CLEAR.
- in_ready is a function of state only; it has no combinational path from in_valid.
- Skew datapath, registered, shifts every cycle:
  - Stage-0 register captures (accepted ? in_a/in_b : 0) each cycle in FEED, and 0 in all other states.
  - Lane r has an r-deep delay line after stage 0. a_left[r](t) = slice captured at t-1-r; b_top[c] likewise with delay c.
  - Lane 0 therefore lags acceptance by 1 cycle; lane N-1 lags by N cycles.
- Skew registers shift every cycle in every state. IDLE, CLEAR and DONE feed zeros, so lanes self-flush.
- Values pass through unmodified: no sign extension, no arithmetic.
- Timing with continuous in_valid: start sampled at edge 0 -> CLEAR cycle 1 -> FEED cycles 2..K+1 -> DRAIN K+2..K+2N -> done at cycle K+2N+1.
- Each bubble cycle delays done by one cycle.

Test Plan:
- N=4, k_len=1, in_a=[1,2,3,4], in_b=[5,6,7,8], in_valid held high.
  - clear_acc at cycle 1; done exactly at cycle 10.
  - c_out[r][c] = a_r*b_c, e.g. c_out[3][1]=24, c_out[0][0]=5.
- Skew check for the same stimulus:
  - a_left[0]=1 at cycle 3, a_left[1]=2 at 4, a_left[3]=4 at 6.
  - b_top[c] mirrors a_left, same timing.
  - All lanes are 0 elsewhere.
- k_len=4, A=identity, B=random signed including -32768 and 32767, in_valid toggling 1,0,0,1,1,0,1.
  - c_out == B.
  - Done is delayed by exactly 3 cycles versus continuous valid.
  - en stays high through the bubbles.
- k_len=0:
  - CLEAR at cycle 1, done at cycle 2.
  - en never asserts; in_ready never asserts; c_out all 0.
- Back-to-back: start pulsed during FEED is ignored. After done, a new tile with a=-3, b=7, k_len=1 yields c_out[r][c]=-21 with no residue from the prior tile.
- rst asserted mid-FEED (2 of 4 slices accepted):
  - Next cycle: IDLE, busy=0, all outputs 0, no done.
  - A fresh start afterwards completes normally.
